// File: rtl/key_lock_pkg.sv
// rtl/key_lock_pkg.sv - shared types and constants for the key lock client and arbiter
package key_lock_pkg;

    localparam int KL_KEY_WIDTH = 32;
    localparam logic [KL_KEY_WIDTH-1:0] KL_IDLE_KEY = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRY     = 2'd1,
        BACKOFF = 2'd2,
        HOLD    = 2'd3
    } lock_state_t;

endpackage

// File: rtl/key_lock_client.sv
// rtl/key_lock_client.sv - requester-side key lock: acquire, hold and release through the mutex arbiter
module key_lock_client
    import key_lock_pkg::*;
#(
    parameter int KEY_WIDTH = KL_KEY_WIDTH,
    parameter logic [KEY_WIDTH-1:0] IDLE_KEY = KEY_WIDTH'(KL_IDLE_KEY),
    parameter int BACKOFF_CYCLES = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 acq_req,
    input  logic [KEY_WIDTH-1:0] acq_key,
    output logic                 acq_ack,
    output logic                 acq_err,
    input  logic                 release_lock,
    output logic                 busy,
    input  logic                 grant,
    input  logic                 other_locked,
    output logic [KEY_WIDTH-1:0] plan_key,
    output logic [KEY_WIDTH-1:0] locked_key,
    output logic [CNT_WIDTH-1:0] contention_count
);

    lock_state_t          state, state_next;
    logic [7:0]           backoff_cnt, backoff_next;
    logic [KEY_WIDTH-1:0] plan_next, locked_next;
    logic [CNT_WIDTH-1:0] count_next;
    logic                 ack_next, err_next;

    // Every output is a register; grant/other_locked only reach outputs through here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            backoff_cnt      <= 8'd0;
            plan_key         <= IDLE_KEY;
            locked_key       <= IDLE_KEY;
            contention_count <= '0;
            acq_ack          <= 1'b0;
            acq_err          <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state            <= state_next;
            backoff_cnt      <= backoff_next;
            plan_key         <= plan_next;
            locked_key       <= locked_next;
            contention_count <= count_next;
            acq_ack          <= ack_next;
            acq_err          <= err_next;
            busy             <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next   = state;
        backoff_next = backoff_cnt;
        plan_next    = plan_key;
        locked_next  = locked_key;
        count_next   = contention_count;
        case (state)
            IDLE: begin
                if (acq_req && (acq_key != IDLE_KEY)) begin
                    plan_next  = acq_key;
                    state_next = TRY;
                end
            end
            TRY: begin
                if (grant) begin
                    if (!other_locked) begin
                        locked_next = plan_key;
                        state_next  = HOLD;
                    end else begin
                        if (contention_count != '1) begin
                            count_next = contention_count + 1'b1;
                        end
                        backoff_next = 8'(BACKOFF_CYCLES);
                        state_next   = BACKOFF;
                    end
                end
            end
            BACKOFF: begin
                if (backoff_cnt <= 8'd1) begin
                    backoff_next = 8'd0;
                    state_next   = TRY;
                end else begin
                    backoff_next = backoff_cnt - 8'd1;
                end
            end
            HOLD: begin
                if (release_lock) begin
                    locked_next = IDLE_KEY;
                    plan_next   = IDLE_KEY;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ack_next = (state == TRY) && grant && !other_locked;
        err_next = (state == IDLE) && acq_req && (acq_key == IDLE_KEY);
    end

endmodule

// File: tb/tb_key_lock_client.sv
// tb/tb_key_lock_client.sv - directed vector bench for key_lock_client plus a two-client arbitration run
module tb_key_lock_client;

    localparam logic [31:0] IK = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        acq_req = 1'b0;
    logic [31:0] acq_key = '0;
    logic        release_lock = 1'b0;
    logic        grant = 1'b0;
    logic        other_locked = 1'b0;
    logic        acq_ack, acq_err, busy;
    logic [31:0] plan_key, locked_key;
    logic [15:0] contention_count;

    logic        phase = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0, rel_a = 1'b0, rel_b = 1'b0;
    logic [31:0] key_ab = '0;
    logic        ack_a, err_a, busy_a, ack_b, err_b, busy_b;
    logic [31:0] plan_a, locked_a, plan_b, locked_b;
    logic [15:0] cnt_a, cnt_b;
    logic        ol_a, ol_b;
    logic        mon_en = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    key_lock_client u_dut (
        .clk(clk), .reset(reset), .acq_req(acq_req), .acq_key(acq_key),
        .acq_ack(acq_ack), .acq_err(acq_err), .release_lock(release_lock), .busy(busy),
        .grant(grant), .other_locked(other_locked), .plan_key(plan_key),
        .locked_key(locked_key), .contention_count(contention_count)
    );

    // Minimal arbiter model: alternating slots, other_locked when the other side holds our planned key.
    assign ol_a = (plan_a != IK) && (locked_b == plan_a);
    assign ol_b = (plan_b != IK) && (locked_a == plan_b);

    key_lock_client u_a (
        .clk(clk), .reset(reset), .acq_req(req_a), .acq_key(key_ab),
        .acq_ack(ack_a), .acq_err(err_a), .release_lock(rel_a), .busy(busy_a),
        .grant(phase), .other_locked(ol_a), .plan_key(plan_a),
        .locked_key(locked_a), .contention_count(cnt_a)
    );

    key_lock_client u_b (
        .clk(clk), .reset(reset), .acq_req(req_b), .acq_key(key_ab),
        .acq_ack(ack_b), .acq_err(err_b), .release_lock(rel_b), .busy(busy_b),
        .grant(~phase), .other_locked(ol_b), .plan_key(plan_b),
        .locked_key(locked_b), .contention_count(cnt_b)
    );

    typedef struct {
        logic        rst, req;
        logic [31:0] key;
        logic        rel, gnt, ol;
        logic        ack, err, bsy;
        logic [31:0] plan, locked;
        logic [15:0] cnt;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        phase = ~phase;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if ((locked_a == locked_b) && (locked_a != IK)) begin
                bad++;
                $display("FAIL exclusion: locked_a=%h locked_b=%h both held", locked_a, locked_b);
            end
        end
    end

    initial begin
        int a_acks, b_acks, waited;
        //                  rst  req  key           rel  gnt  ol   ack  err  bsy  plan          locked        cnt
        vq.push_back(vec_t'{1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,IK,           IK,           16'd0});
        vq.push_back(vec_t'{1'b0,1'b1,32'h10,       1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,32'h10,       IK,           16'd0});
        vq.push_back(vec_t'{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'h10,       IK,           16'd0});
        vq.push_back(vec_t'{1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,32'h10,       32'h10,       16'd0});
        vq.push_back(vec_t'{1'b0,1'b1,32'h20,       1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'h10,       32'h10,       16'd0});
        vq.push_back(vec_t'{1'b0,1'b1,32'h30,       1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,IK,           IK,           16'd0});
        vq.push_back(vec_t'{1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,IK,           IK,           16'd0});
        vq.push_back(vec_t'{1'b0,1'b1,IK,           1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,IK,           IK,           16'd0});
        vq.push_back(vec_t'{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,IK,           IK,           16'd0});
        vq.push_back(vec_t'{1'b0,1'b1,32'h55,       1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,32'h55,       IK,           16'd0});
        vq.push_back(vec_t'{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,32'h55,       IK,           16'd0});
        vq.push_back(vec_t'{1'b0,1'b0,32'h0,        1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,32'h55,       IK,           16'd1});
        vq.push_back(vec_t'{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'h55,       IK,           16'd1});
        vq.push_back(vec_t'{1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,32'h55,       IK,           16'd1});
        vq.push_back(vec_t'{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'h55,       IK,           16'd1});
        vq.push_back(vec_t'{1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,32'h55,       IK,           16'd1});
        vq.push_back(vec_t'{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'h55,       IK,           16'd1});
        vq.push_back(vec_t'{1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,32'h55,       32'h55,       16'd1});
        vq.push_back(vec_t'{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'h55,       32'h55,       16'd1});
        vq.push_back(vec_t'{1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,IK,           IK,           16'd0});

        foreach (vq[i]) begin
            reset        = vq[i].rst;
            acq_req      = vq[i].req;
            acq_key      = vq[i].key;
            release_lock = vq[i].rel;
            grant        = vq[i].gnt;
            other_locked = vq[i].ol;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ack", i),    {31'b0, acq_ack},  {31'b0, vq[i].ack});
            chk($sformatf("v%0d_err", i),    {31'b0, acq_err},  {31'b0, vq[i].err});
            chk($sformatf("v%0d_busy", i),   {31'b0, busy},     {31'b0, vq[i].bsy});
            chk($sformatf("v%0d_plan", i),   plan_key,          vq[i].plan);
            chk($sformatf("v%0d_locked", i), locked_key,        vq[i].locked);
            chk($sformatf("v%0d_cnt", i),    {16'b0, contention_count}, {16'b0, vq[i].cnt});
        end
        acq_req = 1'b0;
        reset   = 1'b0;

        // Two clients contend for key 7; A owns the first grant slot after the request.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mon_en = 1'b1;
        req_a = 1'b1;
        req_b = 1'b1;
        key_ab = 32'h7;
        phase = 1'b0;
        tick();
        req_a = 1'b0;
        req_b = 1'b0;
        a_acks = 0;
        b_acks = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            a_acks += int'(ack_a);
            b_acks += int'(ack_b);
        end
        chk("pair_a_acks", a_acks, 1);
        chk("pair_b_acks", b_acks, 0);
        chk("pair_a_locked", locked_a, 32'h7);
        chk("pair_b_locked", locked_b, IK);
        chk("pair_b_contended", {31'b0, (cnt_b != 16'd0)}, 32'd1);
        chk("pair_b_busy", {31'b0, busy_b}, 32'd1);

        rel_a = 1'b1;
        tick();
        rel_a = 1'b0;
        chk("pair_a_released", locked_a, IK);
        chk("pair_a_idle", {31'b0, busy_a}, 32'd0);

        waited = 0;
        while (!ack_b && waited < 30) begin
            tick();
            waited++;
        end
        chk("pair_b_ack_in_time", {31'b0, ack_b}, 32'd1);
        chk("pair_b_locked_after", locked_b, 32'h7);
        tick();
        mon_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
